// File: rtl/alu_sequencer_if.sv
// Bus between the ALU sequencer and the rest of the CPU: instruction fetch,
// branch flag, data memory handshake, register-file/ALU controls and status.
interface alu_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic [8:0]       instr;
  logic             taken;
  logic             mem_rdy;
  logic [PC_W-1:0]  pc;
  logic [2:0]       alu_op;
  logic [2:0]       ra_sel;
  logic [2:0]       rb_sel;
  logic             rf_we;
  logic             mem_re;
  logic             mem_we;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cyc_cnt;

  // Sequencer side
  modport master (
    input  start, instr, taken, mem_rdy,
    output pc, alu_op, ra_sel, rb_sel, rf_we, mem_re, mem_we, busy, done, cyc_cnt
  );

  // Environment side (memories, register file, ALU, control host)
  modport slave (
    output start, instr, taken, mem_rdy,
    input  pc, alu_op, ra_sel, rb_sel, rf_we, mem_re, mem_we, busy, done, cyc_cnt
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM: fetches one 9-bit instruction at a time, drives the
// shared ALU / register file, resolves pos/beq branches and handshakes lw/sw
// with data memory. Completing the instruction at END_PC ends the program.
module alu_sequencer #(
  parameter int PC_W   = 8,
  parameter int END_PC = 255,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [PC_W-1:0]  PC_ZERO  = {PC_W{1'b0}};
  localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]  END_PC_V = PC_W'(END_PC);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_r;
  logic [PC_W-1:0]  pc_r;
  logic [8:0]       ir_r;
  logic [CNT_W-1:0] cnt_r;

  logic [2:0]       op_s;
  logic             is_mem_s;
  logic             is_branch_s;
  logic             is_lw_s;
  logic             is_sw_s;
  logic             busy_s;
  logic             last_s;
  logic [PC_W-1:0]  off_s;
  logic [PC_W-1:0]  next_pc_s;
  logic [2:0]       alu_op_s;
  logic             rf_we_s;
  logic             mem_re_s;
  logic             mem_we_s;

  assign op_s        = ir_r[8:6];
  assign is_lw_s     = (op_s == 3'b110);
  assign is_sw_s     = (op_s == 3'b111);
  assign is_mem_s    = is_lw_s | is_sw_s;
  assign is_branch_s = (op_s == 3'b011) | (op_s == 3'b101);
  assign busy_s      = (state_r == S_FETCH) | (state_r == S_EXEC) | (state_r == S_MEM);
  assign last_s      = (pc_r == END_PC_V);
  // Branch offset is a signed 6-bit field; the sum is truncated to PC_W.
  assign off_s       = PC_W'($signed(ir_r[5:0]));

  // Next pc: taken branches jump relative, everything else falls through.
  always_comb begin
    if (is_branch_s && bus.taken) begin
      next_pc_s = pc_r + off_s;
    end else begin
      next_pc_s = pc_r + PC_ONE;
    end
  end

  // Control decode from state and IR; forced quiet while reset is asserted so
  // an abort never produces a stray write.
  always_comb begin
    alu_op_s = 3'b000;
    rf_we_s  = 1'b0;
    mem_re_s = 1'b0;
    mem_we_s = 1'b0;
    if (!reset) begin
      case (state_r)
        S_EXEC: begin
          alu_op_s = op_s;
          rf_we_s  = ~is_mem_s & ~is_branch_s;
        end
        S_MEM: begin
          alu_op_s = op_s;
          mem_re_s = is_lw_s;
          mem_we_s = is_sw_s;
          rf_we_s  = is_lw_s & bus.mem_rdy;
        end
        default: begin
          alu_op_s = 3'b000;
          rf_we_s  = 1'b0;
        end
      endcase
    end else begin
      alu_op_s = 3'b000;
      rf_we_s  = 1'b0;
    end
  end

  // Sequencer state, pc, IR and the saturating busy-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      pc_r    <= PC_ZERO;
      ir_r    <= 9'b0_0000_0000;
      cnt_r   <= CNT_ZERO;
    end else begin
      if (busy_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      case (state_r)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            pc_r    <= PC_ZERO;
            cnt_r   <= CNT_ZERO;
            state_r <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir_r    <= bus.instr;
          state_r <= S_EXEC;
        end
        S_EXEC: begin
          if (is_mem_s) begin
            state_r <= S_MEM;
          end else begin
            pc_r    <= next_pc_s;
            state_r <= last_s ? S_DONE : S_FETCH;
          end
        end
        S_MEM: begin
          if (bus.mem_rdy) begin
            pc_r    <= next_pc_s;
            state_r <= last_s ? S_DONE : S_FETCH;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pc      = pc_r;
  assign bus.alu_op  = alu_op_s;
  assign bus.ra_sel  = ir_r[5:3];
  assign bus.rb_sel  = ir_r[2:0];
  assign bus.rf_we   = rf_we_s;
  assign bus.mem_re  = mem_re_s;
  assign bus.mem_we  = mem_we_s;
  assign bus.busy    = busy_s;
  assign bus.done    = (state_r == S_DONE);
  assign bus.cyc_cnt = cnt_r;

endmodule
